encoder_8_3_seq: RTL and testbench

//   Sequential 8-to-3 priority encoder; inverse of the 3-to-8 decoder block.

---
 rtl/encoder_8_3_seq_if.sv | 25 ++
 rtl/encoder_8_3_seq.sv | 101 ++++++++++
 tb/tb_encoder_8_3_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/encoder_8_3_seq_if.sv
// Handshake bundle for the sequential 8-to-3 encoder: request side (En/I/in_valid/in_ready)
// and code side (Y/out_valid/out_ready/last).
interface encoder_8_3_seq_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         En;
  logic [N-1:0] I;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic         last;

  modport slave (
    input  En, I, in_valid, out_ready,
    output in_ready, Y, out_valid, last
  );

  modport master (
    output En, I, in_valid, out_ready,
    input  in_ready, Y, out_valid, last
  );
endinterface

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 priority encoder: serialises a captured multi-hot vector into one
// index per output beat. Define ENC_LSB_FIRST_EN to emit lowest index first.
module encoder_8_3_seq #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic            clk,
  input  logic            rst,
  encoder_8_3_seq_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] y_q, y_d;
  logic         out_valid_q, out_valid_d;
  logic         last_q, last_d;

  logic [N-1:0] src_vec;
  logic [W-1:0] src_idx;

  // Index of the set bit that goes out next: highest by default, lowest when inverted.
  function automatic logic [W-1:0] pick_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
`ifdef ENC_LSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
`else
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
`endif
    return idx;
  endfunction

  function automatic logic one_hot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  assign bus.in_ready  = (state_q == IDLE) & bus.En & ~rst;
  assign bus.Y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.last      = last_q;

  assign src_vec = (state_q == IDLE) ? bus.I : pending_q;
  assign src_idx = pick_idx(src_vec);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        // An all-zero vector is consumed without producing a beat.
        if (bus.in_valid && bus.in_ready && (src_vec != '0)) begin
          y_d         = src_idx;
          pending_d   = src_vec & ~(N'(1) << src_idx);
          last_d      = one_hot(src_vec);
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          if (pending_q != '0) begin
            y_d       = src_idx;
            pending_d = src_vec & ~(N'(1) << src_idx);
            last_d    = one_hot(src_vec);
          end else begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Scoreboard bench for encoder_8_3_seq: directed scenarios plus randomized vectors,
// expected codes derived from the set bits of each accepted vector.
module tb_encoder_8_3_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  encoder_8_3_seq_if #(.N(8), .W(3)) bus ();

  encoder_8_3_seq #(.N(8), .W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // expected beat: {index[2:0], last}
  logic [3:0] exp_q[$];

  // out_ready source: 0 = low, 1 = high, 2 = random per cycle
  int   rdy_mode = 1;
  logic rnd_bit  = 1'b0;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign bus.out_ready = (rdy_mode == 1) || ((rdy_mode == 2) && rnd_bit);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: list the set bits in emission order; the final one carries last.
  task automatic push_expected(input logic [7:0] v);
    int idxs[$];
    for (int i = 0; i < 8; i++) begin
`ifdef ENC_LSB_FIRST_EN
      if (v[i]) idxs.push_back(i);
`else
      if (v[7 - i]) idxs.push_back(7 - i);
`endif
    end
    for (int k = 0; k < idxs.size(); k++)
      exp_q.push_back({3'(idxs[k]), (k == idxs.size() - 1) ? 1'b1 : 1'b0});
  endtask

  // Monitor: every presented beat must match the queue head; popped on handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        chk("Y", int'(bus.Y), int'(exp_q[0][3:1]));
        chk("last", int'(bus.last), int'(exp_q[0][0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present v until accepted (bounded); model pushed at the accepting edge.
  task automatic load(input logic [7:0] v);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    bus.I        = v;
    bus.in_valid = 1'b1;
    step();
    push_expected(v);
    bus.in_valid = 1'b0;
    bus.I        = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", (exp_q.size() != 0 || bus.out_valid) ? 1 : 0, 0);
  endtask

  initial begin
    logic [7:0] v;
    rst          = 1'b1;
    bus.En       = 1'b1;
    bus.in_valid = 1'b0;
    bus.I        = 8'h00;
    rdy_mode     = 1;

    // Reset state
    step();
    step();
    chk("rst_Y", int'(bus.Y), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_last", int'(bus.last), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(bus.in_ready), 1);

    // Three-bit vector, free-flowing output
    load(8'hA4);
    chk("load_latency_valid", int'(bus.out_valid), 1);
    chk("load_in_ready_low", int'(bus.in_ready), 0);
    drain();
    chk("in_ready_after_drain", int'(bus.in_ready), 1);

    // Stalled output holds the first code
    rdy_mode = 0;
    load(8'h81);
    repeat (3) step();
    chk("stall_valid_held", int'(bus.out_valid), 1);
    rdy_mode = 1;
    drain();

    // Zero vector is dropped; En=0 blocks loading
    load(8'h00);
    chk("zero_no_beat", int'(bus.out_valid), 0);
    chk("zero_in_ready", int'(bus.in_ready), 1);
    bus.En       = 1'b0;
    bus.in_valid = 1'b1;
    bus.I        = 8'h10;
    #1;
    chk("en0_in_ready", int'(bus.in_ready), 0);
    step();
    step();
    chk("en0_no_load", int'(bus.out_valid), 0);
    bus.in_valid = 1'b0;
    bus.En       = 1'b1;

    // Reset in the middle of a burst
    load(8'hFF);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_Y", int'(bus.Y), 0);
    chk("midrst_last", int'(bus.last), 0);
    rst = 1'b0;
    load(8'h02);
    drain();

    // Randomized vectors with random back-pressure
    rdy_mode = 2;
    for (int t = 0; t < 60; t++) begin
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      load(v);
      if (v != 8'h00) chk("rand_latency_valid", int'(bus.out_valid), 1);
      repeat ($urandom_range(0, 2)) step();
    end
    rdy_mode = 1;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_in_ready", int'(bus.in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
